peak_detector: RTL and testbench

PEAK_DETECTOR -- requirements
Module: peak_detector

---
 rtl/package_settings.sv | 14 +
 rtl/peak_detector.sv | 155 +++++++++++++++
 tb/tb_peak_detector.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/package_settings.sv
// Shared widths and the peak detector state type.
package package_settings;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int SIZE_TIMESTAMP   = 16;
    localparam int SIZE_PEAK_COUNT  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ABOVE,
        HOLDOFF
    } peak_state_t;

endpackage

// File: rtl/peak_detector.sv
// Threshold-based peak detector for the filter output stream: reports the maximum
// sample of each above-threshold pulse. Define PEAK_DETECTOR_PILEUP_EN to add peak_pileup.
module peak_detector
    import package_settings::*;
#(
    parameter int HOLDOFF_CYCLES = 8,
    parameter int MAX_WIDTH      = 255
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    output logic                               peak_valid,
    output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
    output logic        [SIZE_TIMESTAMP-1:0]   peak_time,
    output logic                               peak_overflow,
    output logic        [SIZE_PEAK_COUNT-1:0]  peak_count,
    output logic                               busy
`ifdef PEAK_DETECTOR_PILEUP_EN
    ,
    output logic                               peak_pileup
`endif
);

    localparam int WIDTH_BITS = (MAX_WIDTH < 2) ? 1 : $clog2(MAX_WIDTH + 1);
    localparam int HOLD_BITS  = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES);

    peak_state_t                        state, state_n;
    logic signed [SIZE_FILTER_DATA-1:0] s;
    logic        [SIZE_TIMESTAMP-1:0]   ts;
    logic signed [SIZE_FILTER_DATA-1:0] thr_q, thr_n;
    logic signed [SIZE_FILTER_DATA-1:0] max_q, max_n;
    logic        [SIZE_TIMESTAMP-1:0]   time_q, time_n;
    logic        [WIDTH_BITS-1:0]       width_q, width_n;
    logic        [HOLD_BITS-1:0]        hold_q, hold_n;
    logic                               report, forced;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_n = state;
        thr_n   = thr_q;
        max_n   = max_q;
        time_n  = time_q;
        width_n = width_q;
        hold_n  = hold_q;
        report  = 1'b0;
        forced  = 1'b0;
        unique case (state)
            IDLE: begin
                if (s > threshold) begin
                    state_n = ABOVE;
                    thr_n   = threshold;
                    max_n   = s;
                    time_n  = ts;
                    width_n = WIDTH_BITS'(1);
                end
            end
            ABOVE: begin
                // Compare against the threshold captured at pulse start, not the live port.
                if (s <= thr_q) begin
                    report = 1'b1;
                end else begin
                    if (s > max_q) begin
                        max_n  = s;
                        time_n = ts;
                    end
                    width_n = width_q + 1'b1;
                    if (width_q >= WIDTH_BITS'(MAX_WIDTH - 1)) begin
                        report = 1'b1;
                        forced = 1'b1;
                    end
                end
            end
            HOLDOFF: begin
                if (hold_q == HOLD_BITS'(HOLDOFF_CYCLES - 1)) state_n = IDLE;
                else                                          hold_n  = hold_q + 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (report) begin
            state_n = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
            hold_n  = '0;
        end
    end

`ifdef PEAK_DETECTOR_PILEUP_EN
    logic                               dip_q, dip_n, pile_q, pile_n;
    logic signed [SIZE_FILTER_DATA-1:0] prev_q;

    // A dip below the running max followed by any rise marks a second overlapping pulse.
    always_comb begin
        dip_n  = dip_q;
        pile_n = pile_q;
        if (state == IDLE) begin
            dip_n  = 1'b0;
            pile_n = 1'b0;
        end else if (state == ABOVE && s > thr_q) begin
            if (s < max_q)             dip_n  = 1'b1;
            if (dip_q && s > prev_q)   pile_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dip_q       <= 1'b0;
            pile_q      <= 1'b0;
            prev_q      <= '0;
            peak_pileup <= 1'b0;
        end else begin
            dip_q  <= dip_n;
            pile_q <= pile_n;
            prev_q <= s;
            if (report) peak_pileup <= pile_n;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            s              <= '0;
            ts             <= '0;
            thr_q          <= '0;
            max_q          <= '0;
            time_q         <= '0;
            width_q        <= '0;
            hold_q         <= '0;
            peak_valid     <= 1'b0;
            peak_amplitude <= '0;
            peak_time      <= '0;
            peak_overflow  <= 1'b0;
            peak_count     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state      <= state_n;
            s          <= input_data;
            ts         <= ts + 1'b1;
            thr_q      <= thr_n;
            max_q      <= max_n;
            time_q     <= time_n;
            width_q    <= width_n;
            hold_q     <= hold_n;
            peak_valid <= report;
            if (report) begin
                peak_amplitude <= max_n;
                peak_time      <= time_n;
                peak_overflow  <= forced;
                if (peak_count != '1) peak_count <= peak_count + 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_peak_detector.sv
// Directed bench for peak_detector: default, short-width and zero-holdoff instances.
`timescale 1ns/1ps
module tb_peak_detector;
    import package_settings::*;

    typedef logic signed [SIZE_FILTER_DATA-1:0] sample_t;
    typedef logic        [SIZE_TIMESTAMP-1:0]   stamp_t;
    typedef logic        [SIZE_PEAK_COUNT-1:0]  count_t;

    logic    clk   = 1'b0;
    logic    reset = 1'b1;
    sample_t input_data = '0;
    sample_t threshold  = 16'sd100;

    logic    valid_d, ovf_d, busy_d;
    sample_t amp_d;
    stamp_t  time_d;
    count_t  count_d;
    logic    valid_w, ovf_w, busy_w;
    sample_t amp_w;
    stamp_t  time_w;
    count_t  count_w;
    logic    valid_z, ovf_z, busy_z;
    sample_t amp_z;
    stamp_t  time_z;
    count_t  count_z;
`ifdef PEAK_DETECTOR_PILEUP_EN
    logic    pile_d, pile_w, pile_z;
`endif

    int     n_cmp = 0;
    int     n_bad = 0;
    stamp_t tb_ts;
    stamp_t t_pk;

    peak_detector dut (
        .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
        .peak_valid(valid_d), .peak_amplitude(amp_d), .peak_time(time_d),
        .peak_overflow(ovf_d), .peak_count(count_d), .busy(busy_d)
`ifdef PEAK_DETECTOR_PILEUP_EN
        , .peak_pileup(pile_d)
`endif
    );

    peak_detector #(.HOLDOFF_CYCLES(4), .MAX_WIDTH(4)) dut_w (
        .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
        .peak_valid(valid_w), .peak_amplitude(amp_w), .peak_time(time_w),
        .peak_overflow(ovf_w), .peak_count(count_w), .busy(busy_w)
`ifdef PEAK_DETECTOR_PILEUP_EN
        , .peak_pileup(pile_w)
`endif
    );

    peak_detector #(.HOLDOFF_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
        .peak_valid(valid_z), .peak_amplitude(amp_z), .peak_time(time_z),
        .peak_overflow(ovf_z), .peak_count(count_z), .busy(busy_z)
`ifdef PEAK_DETECTOR_PILEUP_EN
        , .peak_pileup(pile_z)
`endif
    );

    always #5 clk = ~clk;

    // Reference time base: counts rising edges since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_ts <= '0;
        else        tb_ts <= tb_ts + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one sample at a falling edge and advance to the next falling edge.
    task automatic step(input sample_t d);
        input_data = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input sample_t d);
        for (int i = 0; i < n; i++) step(d);
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid", valid_d, 0);
        check("rst_amp",   amp_d,   0);
        check("rst_time",  time_d,  0);
        check("rst_ovf",   ovf_d,   0);
        check("rst_count", count_d, 0);
        check("rst_busy",  busy_d,  0);
        reset = 1'b1;
        idle(4, 0);

        // Basic pulse 0,150,300,250,50 at threshold 100
        step(0);
        step(150);
        t_pk = tb_ts;
        step(300);
        check("above_busy", busy_d, 1);
        step(250);
        step(50);
        check("latency_early", valid_d, 0);
        step(0);
        check("basic_valid", valid_d, 1);
        check("basic_amp",   amp_d,   300);
        check("basic_time",  time_d,  32'(stamp_t'(t_pk + 1'b1)));
        check("basic_count", count_d, 1);
        check("basic_ovf",   ovf_d,   0);
        check("z_basic_cnt", count_z, 1);
`ifdef PEAK_DETECTOR_PILEUP_EN
        check("basic_pile",  pile_d,  0);
`endif
        step(0);
        check("valid_1cyc",  valid_d, 0);
        check("amp_held",    amp_d,   300);

        // Pulse inside the holdoff window: ignored by dut, seen by the zero-holdoff dut_z
        step(0);
        step(500);
        step(500);
        step(0);
        step(0);
        check("z_pulse_valid", valid_z, 1);
        check("z_pulse_amp",   amp_z,   500);
        check("z_pulse_count", count_z, 2);
        check("holdoff_busy",  busy_d,  1);
        idle(6, 0);
        check("holdoff_ignored", count_d, 1);
        check("holdoff_done",    busy_d,  0);

        // Same pulse after holdoff expires
        step(500);
        step(500);
        step(0);
        step(0);
        check("after_hold_valid", valid_d, 1);
        check("after_hold_amp",   amp_d,   500);
        check("after_hold_count", count_d, 2);
        check("z_after_count",    count_z, 3);

        // Reset mid-ABOVE discards the pulse
        idle(10, 0);
        step(150);
        step(300);
        step(300);
        check("pre_reset_busy", busy_d, 1);
        input_data = 0;
        reset = 1'b0;
        #1;
        check("inrst_valid", valid_d, 0);
        check("inrst_amp",   amp_d,   0);
        check("inrst_time",  time_d,  0);
        check("inrst_count", count_d, 0);
        check("inrst_busy",  busy_d,  0);
        @(negedge clk);
        reset = 1'b1;
        step(0);
        check("rel_busy",  busy_d,  0);
        check("rel_valid", valid_d, 0);
        check("rel_amp",   amp_d,   0);
        idle(4, 0);
        check("rel_no_report", count_d, 0);

        // Forced report at MAX_WIDTH=4 with six samples of 200
        t_pk = tb_ts;
        idle(4, 200);
        check("w_early",  valid_w, 0);
        step(200);
        check("w_valid",  valid_w, 1);
        check("w_ovf",    ovf_w,   1);
        check("w_amp",    amp_w,   200);
        check("w_time",   time_w,  32'(stamp_t'(t_pk + 1'b1)));
        check("w_count",  count_w, 1);
        check("w_hold",   busy_w,  1);
        step(200);
        idle(12, 0);
        check("w_no_retrig", count_w, 1);
        check("d_long_ovf",  ovf_d,   0);
        check("d_long_cnt",  count_d, 1);

        // Negative threshold
        idle(3, -100);
        threshold = -16'sd50;
        idle(3, -100);
        t_pk = tb_ts;
        step(-20);
        step(-60);
        step(-100);
        check("neg_valid", valid_d, 1);
        check("neg_amp",   amp_d,   -20);
        check("neg_time",  time_d,  32'(stamp_t'(t_pk + 1'b1)));
        check("neg_count", count_d, 2);
        idle(10, -100);
        threshold = 16'sd100;
        idle(3, 0);

        // Double-humped pulse; threshold raised mid-pulse must be ignored
        step(150);
        t_pk = tb_ts;
        step(400);
        threshold = 16'sd1000;
        step(200);
        step(350);
        check("thr_latched", valid_d, 0);
        check("thr_busy",    busy_d,  1);
        step(50);
        step(0);
        threshold = 16'sd100;
        check("pile_valid", valid_d, 1);
        check("pile_amp",   amp_d,   400);
        check("pile_time",  time_d,  32'(stamp_t'(t_pk + 1'b1)));
        check("pile_count", count_d, 3);
`ifdef PEAK_DETECTOR_PILEUP_EN
        check("pile_flag",  pile_d,  1);
`endif
        idle(10, 0);

        // Timestamp wrap inside a pulse: max sample lands on tb_ts=FFFF, stamped 0000
        for (int i = 0; i < 70000 && tb_ts != 16'hFFFC; i++) step(0);
        if (tb_ts != 16'hFFFC) begin
            n_cmp++;
            n_bad++;
            $error("FAIL wrap_reach: observed 0x%0h expected 0xfffc", tb_ts);
        end
        step(150);
        step(200);
        step(250);
        t_pk = tb_ts;
        step(300);
        step(280);
        step(50);
        step(0);
        check("wrap_valid", valid_d, 1);
        check("wrap_amp",   amp_d,   300);
        check("wrap_time",  time_d,  32'(stamp_t'(t_pk + 1'b1)));
        check("wrap_count", count_d, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
